// File: rtl/gpr_multi.sv
// Two-write, two-read register file with a per-register busy scoreboard.
// Reads bypass same-cycle writes; BusyCount tracks the population of busy bits.
module gpr_multi #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              WriteEnA,
    input  logic              WriteEnB,
    input  logic [ADDR_W-1:0] WriteRegA,
    input  logic [ADDR_W-1:0] WriteRegB,
    input  logic [DATA_W-1:0] WriteDataA,
    input  logic [DATA_W-1:0] WriteDataB,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic [ADDR_W:0]   BusyCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_a;
    logic              wr_b;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] bits);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt = cnt + (ADDR_W + 1)'(bits[i]);
        return cnt;
    endfunction

    assign wr_a = WriteEnA && !is_zero_reg(WriteRegA);
    assign wr_b = WriteEnB && !is_zero_reg(WriteRegB);

    // Writes clear busy first, then a same-edge issue re-marks it: the newer producer wins.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_a && WriteRegA == ADDR_W'(i))
                busy_nxt[i] = 1'b0;
            if (wr_b && WriteRegB == ADDR_W'(i))
                busy_nxt[i] = 1'b0;
            if (Issue && IssueReg == ADDR_W'(i))
                busy_nxt[i] = 1'b1;
        end
        if (ZERO_REG != 0)
            busy_nxt[0] = 1'b0;
        count_nxt = popcount(busy_nxt);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy      <= '0;
            BusyCount <= '0;
        end else begin
            if (wr_a)
                regs[WriteRegA] <= WriteDataA;
            if (wr_b)
                regs[WriteRegB] <= WriteDataB;
            busy      <= busy_nxt;
            BusyCount <= count_nxt;
        end
    end

    // Bypass is suppressed during reset so outputs read zero immediately.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (is_zero_reg(addr))
            return '0;
        if (!RST && wr_b && WriteRegB == addr)
            return WriteDataB;
        if (!RST && wr_a && WriteRegA == addr)
            return WriteDataA;
        return regs[addr];
    endfunction

    always_comb begin
        ReadData1 = read_port(ReadReg1);
        ReadData2 = read_port(ReadReg2);
        Busy1     = busy[ReadReg1];
        Busy2     = busy[ReadReg2];
    end

endmodule

// File: tb/tb_gpr_multi.sv
// Directed bench for gpr_multi: bypass, dual-write priority, zero register,
// scoreboard counting and asynchronous reset.
module tb_gpr_multi;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              CLK;
    logic              RST;
    logic [ADDR_W-1:0] ReadReg1, ReadReg2;
    logic [DATA_W-1:0] ReadData1, ReadData2;
    logic              Busy1, Busy2;
    logic              WriteEnA, WriteEnB;
    logic [ADDR_W-1:0] WriteRegA, WriteRegB;
    logic [DATA_W-1:0] WriteDataA, WriteDataB;
    logic              Issue;
    logic [ADDR_W-1:0] IssueReg;
    logic [ADDR_W:0]   BusyCount;

    int n_cmp = 0;
    int n_mis = 0;

    gpr_multi #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .CLK(CLK), .RST(RST),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Busy1(Busy1), .Busy2(Busy2),
        .WriteEnA(WriteEnA), .WriteEnB(WriteEnB),
        .WriteRegA(WriteRegA), .WriteRegB(WriteRegB),
        .WriteDataA(WriteDataA), .WriteDataB(WriteDataB),
        .Issue(Issue), .IssueReg(IssueReg),
        .BusyCount(BusyCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WriteEnA = 0; WriteEnB = 0; Issue = 0;
    endtask

    initial begin
        RST = 1; idle();
        ReadReg1 = 0; ReadReg2 = 0;
        WriteRegA = 0; WriteRegB = 0; IssueReg = 0;
        WriteDataA = 0; WriteDataB = 0;
        tick(); tick();
        RST = 0;
        tick();

        // Post-reset sweep of all addresses
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = ADDR_W'(i);
            ReadReg2 = ADDR_W'(31 - i);
            #1;
            check("rst_rd1", ReadData1, 0);
            check("rst_rd2", ReadData2, 0);
            check("rst_busy1", Busy1, 0);
        end
        check("rst_cnt", BusyCount, 0);

        // Same-cycle bypass then stored value
        WriteEnA = 1; WriteRegA = 3; WriteDataA = 32'h12345678; ReadReg1 = 3;
        #1 check("byp_a", ReadData1, 32'h12345678);
        tick(); idle();
        #1 check("stored_a", ReadData1, 32'h12345678);

        // Both ports to reg 7, port B wins
        WriteEnA = 1; WriteRegA = 7; WriteDataA = 32'hAAAA0000;
        WriteEnB = 1; WriteRegB = 7; WriteDataB = 32'h0000BBBB;
        ReadReg1 = 7; ReadReg2 = 7;
        #1 check("byp_b_pri1", ReadData1, 32'h0000BBBB);
        check("byp_b_pri2", ReadData2, 32'h0000BBBB);
        tick(); idle();
        #1 check("stored_b_pri", ReadData1, 32'h0000BBBB);

        // Zero register ignores writes and issues
        WriteEnA = 1; WriteRegA = 0; WriteDataA = 32'hFFFFFFFF;
        Issue = 1; IssueReg = 0; ReadReg1 = 0;
        #1 check("zero_byp", ReadData1, 0);
        tick(); idle();
        #1 check("zero_rd", ReadData1, 0);
        check("zero_busy", Busy1, 0);
        check("zero_cnt", BusyCount, 0);

        // Scoreboard
        Issue = 1; IssueReg = 5;
        tick();
        IssueReg = 9;
        tick(); idle();
        ReadReg1 = 5; ReadReg2 = 9;
        #1 check("sb_cnt2", BusyCount, 2);
        check("sb_busy5", Busy1, 1);
        check("sb_busy9", Busy2, 1);
        WriteEnA = 1; WriteRegA = 5; WriteDataA = 32'h55;
        Issue = 1; IssueReg = 5;
        tick(); idle();
        #1 check("sb_reissue_busy", Busy1, 1);
        check("sb_reissue_cnt", BusyCount, 2);
        check("sb_rd5", ReadData1, 32'h55);
        WriteEnB = 1; WriteRegB = 9; WriteDataB = 32'h99;
        #1 check("sb_no_clr_byp", Busy2, 1);
        tick(); idle();
        #1 check("sb_clr9", Busy2, 0);
        check("sb_cnt1", BusyCount, 1);
        check("sb_rd9", ReadData2, 32'h99);

        // Asynchronous reset between edges
        WriteEnA = 1; WriteRegA = 12; WriteDataA = 32'h00C0FFEE;
        Issue = 1; IssueReg = 20;
        tick(); idle();
        ReadReg1 = 12; ReadReg2 = 5;
        #1 check("pre_rst_cnt", BusyCount, 2);
        check("pre_rst_rd", ReadData1, 32'h00C0FFEE);
        #1;
        RST = 1;
        WriteEnA = 1; WriteRegA = 13; WriteDataA = 32'h0000DEAD;
        #1 check("arst_rd", ReadData1, 0);
        check("arst_busy", Busy2, 0);
        check("arst_cnt", BusyCount, 0);
        tick();
        RST = 0; idle();
        ReadReg1 = 13; ReadReg2 = 3;
        #1 check("rst_wr_dropped", ReadData1, 0);
        check("rst_cleared3", ReadData2, 0);
        check("rst_cnt_hold", BusyCount, 0);

        // First edge after reset is normal
        WriteEnA = 1; WriteRegA = 4; WriteDataA = 32'h4444;
        Issue = 1; IssueReg = 6;
        tick(); idle();
        ReadReg1 = 4; ReadReg2 = 6;
        #1 check("post_rst_wr", ReadData1, 32'h4444);
        check("post_rst_busy", Busy2, 1);
        check("post_rst_cnt", BusyCount, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
